// File: rtl/scan_test_controller_pkg.sv
// scan_test_controller_pkg: FSM encodings, scan-enable levels and width helper
package scan_test_controller_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic SE_SHIFT = 1'b1;
  localparam logic SE_CAPT  = 1'b0;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/scan_test_controller_if.sv
// scan_test_controller_if: run control, scan chain pins and parallel response port
interface scan_test_controller_if #(
  parameter int CHAIN_LEN = 4,
  parameter int PW = 4
);
  logic start;
  logic so;
  logic se;
  logic si;
  logic busy;
  logic done;
  logic resp_valid;
  logic [CHAIN_LEN-1:0] resp_data;
  logic [PW-1:0] resp_pat;
  modport master(input start, so, output se, si, busy, done, resp_valid, resp_data, resp_pat);
  modport slave(output start, so, input se, si, busy, done, resp_valid, resp_data, resp_pat);
endinterface

// File: rtl/scan_test_controller_resp_unloader.sv
// scan_test_controller_resp_unloader: collects SO bits and publishes each completed unload
module scan_test_controller_resp_unloader #(
  parameter int CHAIN_LEN = 4,
  parameter int PW = 4,
  parameter int BW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 so,
  input  logic                 sample_en,
  input  logic [BW-1:0]        bit_idx,
  input  logic                 emit,
  input  logic [PW-1:0]        emit_pat,
  output logic                 resp_valid,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic [PW-1:0]        resp_pat
);
  logic [CHAIN_LEN-1:0] sr, nxt;
  // the final SO bit lands in the same edge that publishes the word
  always_comb begin
    nxt = sr;
    if (sample_en) nxt[bit_idx] = so;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_pat <= '0;
    end else begin
      sr <= nxt;
      resp_valid <= emit;
      if (emit) begin
        resp_data <= nxt;
        resp_pat <= emit_pat;
      end
    end
endmodule

// File: rtl/scan_test_controller.sv
// scan_test_controller: drives SE/SI to load every pattern into a scan chain and
// unloads each captured response while the next pattern shifts in
module scan_test_controller
  import scan_test_controller_pkg::*;
#(
  parameter int CHAIN_LEN = 4,
  parameter int NUM_PATTERNS = 2 ** CHAIN_LEN,
  parameter int PW = idx_w(NUM_PATTERNS)
) (
  input logic clk,
  input logic rst,
  scan_test_controller_if.master bus
);
  localparam int BW = idx_w(CHAIN_LEN);
  logic [2:0] state;
  logic [BW-1:0] bit_cnt;
  logic [PW-1:0] pat_cnt;
  logic [CHAIN_LEN-1:0] pat_ext;
  logic shifting, last, emit;
  assign shifting = state == S_SHIFT || state == S_FLUSH;
  assign last = bit_cnt == BW'(CHAIN_LEN - 1);
  assign pat_ext = CHAIN_LEN'(pat_cnt);
  // the first shift of a run unloads undefined chain contents, so it is not published
  assign emit = shifting && last && (state == S_FLUSH || pat_cnt != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      bit_cnt <= '0;
      pat_cnt <= '0;
    end else begin
      bit_cnt <= shifting && !last ? bit_cnt + 1'b1 : '0;
      case (state)
        S_IDLE: if (bus.start) begin
          state <= S_SHIFT;
          pat_cnt <= '0;
        end
        S_SHIFT: if (last) state <= S_CAPT;
        S_CAPT: if (pat_cnt == PW'(NUM_PATTERNS - 1)) state <= S_FLUSH;
          else begin
            state <= S_SHIFT;
            pat_cnt <= pat_cnt + 1'b1;
          end
        S_FLUSH: if (last) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  assign bus.se = shifting ? SE_SHIFT : SE_CAPT;
  assign bus.si = state == S_SHIFT && pat_ext[bit_cnt];
  assign bus.busy = shifting || state == S_CAPT;
  assign bus.done = state == S_DONE;
  scan_test_controller_resp_unloader #(
    .CHAIN_LEN(CHAIN_LEN),
    .PW(PW),
    .BW(BW)
  ) u_unload (
    .clk(clk),
    .rst(rst),
    .so(bus.so),
    .sample_en(shifting),
    .bit_idx(bit_cnt),
    .emit(emit),
    .emit_pat(state == S_FLUSH ? pat_cnt : pat_cnt - 1'b1),
    .resp_valid(bus.resp_valid),
    .resp_data(bus.resp_data),
    .resp_pat(bus.resp_pat)
  );
endmodule

// File: tb/tb_scan_test_controller.sv
// tb_scan_test_controller: two controllers (4-flop/16-pattern and 3-flop/5-pattern)
// each driving a behavioural scan chain whose capture function is selectable
module tb_scan_test_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int mode = 0;
  always #5 clk = ~clk;
  scan_test_controller_if #(.CHAIN_LEN(4), .PW(4)) ia ();
  scan_test_controller_if #(.CHAIN_LEN(3), .PW(3)) ib ();
  scan_test_controller dut_a (.clk(clk), .rst(rst), .bus(ia));
  scan_test_controller #(.CHAIN_LEN(3), .NUM_PATTERNS(5)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  // chain: SI enters the top flop, flop 0 drives SO; after a full load flop k holds bit k
  logic [3:0] fa = '0;
  logic [2:0] fb = '0;
  function automatic logic [3:0] cap(input logic [3:0] q, input logic [3:0] mask);
    return (mode == 1 ? ~q : mode == 2 ? q | 4'b0100 : q) & mask;
  endfunction
  always @(posedge clk) fa <= ia.se ? {ia.si, fa[3:1]} : cap(fa, 4'hF);
  always @(posedge clk) fb <= ib.se ? {ib.si, fb[2:1]} : cap({1'b0, fb}, 4'h7) & 3'h7;
  assign ia.so = fa[0];
  assign ib.so = fb[0];
  initial begin
    ia.start = 1'b0;
    ib.start = 1'b0;
  end
  function automatic logic [12:0] obs(input int sel);
    return sel ? {ib.se, ib.si, ib.busy, ib.done, ib.resp_valid, 1'b0, ib.resp_data, 1'b0, ib.resp_pat}
               : {ia.se, ia.si, ia.busy, ia.done, ia.resp_valid, ia.resp_data, ia.resp_pat};
  endfunction
  task automatic drive_start(input int sel, input logic v);
    if (sel) ib.start = v;
    else ia.start = v;
  endtask
  // full run checked cycle by cycle; t counts cycles after the edge that samples start
  task automatic run_check(input string name, input int sel, input int md, input bit repulse, input bit hold);
    int L, N, D, rp, p, k, done_t, nresp;
    logic [12:0] e, o;
    logic [3:0] ep, mask;
    L = sel ? 3 : 4;
    N = sel ? 5 : 16;
    D = N * (L + 1) + L;
    mask = sel ? 4'h7 : 4'hF;
    mode = md;
    done_t = -1;
    nresp = 0;
    rp = repulse ? int'($urandom_range(1, D - 3)) : -10;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    drive_start(sel, 1'b1);
    @(posedge clk);
    #1 if (!hold) drive_start(sel, 1'b0);
    for (int t = 0; t <= D + 1; t++) begin
      @(negedge clk);
      e = '0;
      ep = '0;
      if (t < N * (L + 1)) begin
        p = t / (L + 1);
        k = t % (L + 1);
        ep = 4'(p - 1);
        e[12] = k < L;
        e[11] = k < L ? 1'((p >> k) & 1) : 1'b0;
        e[10] = 1'b1;
        e[8] = k == L && p >= 1;
      end else if (t < D) begin
        e[12] = 1'b1;
        e[10] = 1'b1;
      end else if (t == D) begin
        e[9] = 1'b1;
        e[8] = 1'b1;
        ep = 4'(N - 1);
      end
      if (e[8]) e[7:0] = {cap(ep, mask), ep};
      o = obs(sel);
      if (!e[8]) o[7:0] = '0;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s t=%0d {se,si,busy,done,rv,data,pat} got=%b want=%b", name, t, o, e);
      end
      if (o[9] && done_t < 0) done_t = t;
      if (o[8]) nresp++;
      if (!hold && t == rp) drive_start(sel, 1'b1);
      if (!hold && t == rp + 1) drive_start(sel, 1'b0);
    end
    n_checks++;
    if (done_t + 1 != N * (L + 1) + L + 1) begin
      n_fail++;
      $display("FAIL %s run_length got=%0d want=%0d", name, done_t + 1, N * (L + 1) + L + 1);
    end
    n_checks++;
    if (nresp != N) begin
      n_fail++;
      $display("FAIL %s resp_count got=%0d want=%0d", name, nresp, N);
    end
  endtask
  task automatic test_reset();
    n_checks++;
    if (obs(0) !== '0 || obs(1) !== '0) begin
      n_fail++;
      $display("FAIL reset outputs got=%b/%b want=0", obs(0), obs(1));
    end
  endtask
  task automatic test_abort();
    mode = 0;
    @(negedge clk);
    ia.start = 1'b1;
    @(posedge clk);
    #1 ia.start = 1'b0;
    repeat (27) @(negedge clk);
    n_checks++;
    if (ia.busy !== 1'b1 || ia.se !== 1'b1) begin
      n_fail++;
      $display("FAIL abort pre_busy got=%b%b want=11", ia.busy, ia.se);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (obs(0) !== '0) begin
      n_fail++;
      $display("FAIL abort async_clear got=%b want=0", obs(0));
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs(0) !== '0) begin
      n_fail++;
      $display("FAIL abort stays_idle got=%b want=0", obs(0));
    end
  endtask
  task automatic test_back_to_back();
    run_check("back_to_back", 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({ia.se, ia.si, ia.busy, ia.done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL back_to_back restart got=%b want=1010", {ia.se, ia.si, ia.busy, ia.done});
    end
    ia.start = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    n_checks++;
    if (obs(0) !== '0) begin
      n_fail++;
      $display("FAIL back_to_back abort got=%b want=0", obs(0));
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 test_reset();
    @(negedge clk) rst = 1'b0;
    test_abort();
    run_check("transparent", 0, 0, 1'b0, 1'b0);
    run_check("invert", 0, 1, 1'b0, 1'b0);
    run_check("stuck_bit2", 0, 2, 1'b0, 1'b0);
    run_check("busy_restart", 0, int'($urandom_range(0, 2)), 1'b1, 1'b0);
    run_check("small_chain", 1, 0, 1'b1, 1'b0);
    run_check("small_invert", 1, 1, 1'b0, 1'b0);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
